// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the FIR coefficient path: the loader FSM states,
// the tap-index width and the largest supported filter length. The setup
// block and the FIR top import the same package, so keep it self-contained.
package fir_coeff_pkg;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } coeff_state_e;

    // Tap index counter width; wide enough for COEFF_MAX_LENGTH.
    localparam int COEFF_CNT_WIDTH  = 10;

    // Largest number of taps the index counter can address without wrapping.
    localparam int COEFF_MAX_LENGTH = 1023;

    // Index of the final tap for a filter of the given length.
    function automatic logic [COEFF_CNT_WIDTH-1:0] coeff_last_index(input int length);
        return COEFF_CNT_WIDTH'(length - 1);
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file: LENGTH signed words written one at a time by
// index, read back all at once as a flattened bus (tap k at
// [k*DATA_WIDTH +: DATA_WIDTH]). Cleared only by the asynchronous reset;
// a reload simply overwrites entries as they arrive.
module fir_coeff_bank
    import fir_coeff_pkg::*;
#(
    parameter int LENGTH     = 20,
    parameter int DATA_WIDTH = 18
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [COEFF_CNT_WIDTH-1:0]     wr_index,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic [LENGTH*DATA_WIDTH-1:0]   rd_bus
);

    genvar k;
    generate
        for (k = 0; k < LENGTH; k++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_r;

            // Tap register loads only when its own index is addressed; out-of-range indices hit nothing.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    entry_r <= '0;
                end else if (wr_en && (wr_index == COEFF_CNT_WIDTH'(k))) begin
                    entry_r <= wr_data;
                end else begin
                    entry_r <= entry_r;
                end
            end

            assign rd_bus[k*DATA_WIDTH +: DATA_WIDTH] = entry_r;
        end
    endgenerate

endmodule

// File: rtl/fir_coeff_loader.sv
// Receiving end of the serial FIR coefficient stream. Requests words from the
// setup block, skips the one edge the setup block needs to register its first
// word, captures one coefficient per clock into the bank and checks that the
// setup block's done flag coincides with the final tap. All outputs come
// straight from registers.
module fir_coeff_loader
    import fir_coeff_pkg::*;
#(
    parameter int LENGTH     = 20,
    parameter int DATA_WIDTH = 18
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          loadStart,
    input  logic signed [DATA_WIDTH-1:0]  coeffIn,
    input  logic                          coeffSetFlagIn,
    output logic                          coeffRequest,
    output logic [LENGTH*DATA_WIDTH-1:0]  coeffBus,
    output logic                          coeffReady,
    output logic                          coeffError,
    output logic                          busy
);

    localparam logic [COEFF_CNT_WIDTH-1:0] LAST_INDEX = coeff_last_index(LENGTH);

    coeff_state_e                 state_r;
    coeff_state_e                 state_s;
    logic [COEFF_CNT_WIDTH-1:0]   index_r;
    logic [COEFF_CNT_WIDTH-1:0]   index_s;
    logic                         request_r;
    logic                         request_s;
    logic                         ready_r;
    logic                         ready_s;
    logic                         error_r;
    logic                         error_s;
    logic                         busy_r;
    logic                         busy_s;
    logic                         capture_en_s;
    logic                         last_s;

    assign last_s = (index_r == LAST_INDEX);

    // Next-state and next-output logic; every register holds unless a transition says otherwise.
    always_comb begin
        state_s      = state_r;
        index_s      = index_r;
        request_s    = request_r;
        ready_s      = ready_r;
        error_s      = error_r;
        capture_en_s = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (loadStart) begin
                    state_s   = ARM;
                    request_s = 1'b1;
                    ready_s   = 1'b0;
                    error_s   = 1'b0;
                    index_s   = '0;
                end else begin
                    state_s   = state_r;
                end
            end

            // Setup block needs one edge after seeing the request before its first word is valid.
            ARM: begin
                state_s = CAPTURE;
            end

            CAPTURE: begin
                capture_en_s = 1'b1;
                index_s      = index_r + COEFF_CNT_WIDTH'(1);
                if (coeffSetFlagIn || last_s) begin
                    state_s   = DONE;
                    request_s = 1'b0;
                    if (coeffSetFlagIn && last_s) begin
                        ready_s = 1'b1;
                    end else begin
                        error_s = 1'b1;
                    end
                end else begin
                    state_s = CAPTURE;
                end
            end

            default: begin
                state_s   = IDLE;
                request_s = 1'b0;
                index_s   = '0;
            end
        endcase

        busy_s = (state_s == ARM) || (state_s == CAPTURE);
    end

    // State, index and status registers; reset drops the request immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            index_r   <= '0;
            request_r <= 1'b0;
            ready_r   <= 1'b0;
            error_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            request_r <= request_s;
            ready_r   <= ready_s;
            error_r   <= error_s;
            busy_r    <= busy_s;
        end
    end

    fir_coeff_bank #(
        .LENGTH     (LENGTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (capture_en_s),
        .wr_index (index_r),
        .wr_data  (coeffIn),
        .rd_bus   (coeffBus)
    );

    assign coeffRequest = request_r;
    assign coeffReady   = ready_r;
    assign coeffError   = error_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a behavioural setup-block stub feeds
// the loader, and each scenario task checks timing, status and tap values
// against hand-computed numbers. A second instance covers LENGTH=1.
module tb_fir_coeff_loader;

    localparam int LEN = 20;
    localparam int DW  = 18;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic loadStart = 1'b0;
    logic loadStart1 = 1'b0;

    logic [DW-1:0]      coeffIn;
    logic               coeffSetFlagIn;
    logic               coeffRequest;
    logic [LEN*DW-1:0]  coeffBus;
    logic               coeffReady;
    logic               coeffError;
    logic               busy;

    logic [DW-1:0]      coeffIn1;
    logic               coeffSetFlagIn1;
    logic               coeffRequest1;
    logic [DW-1:0]      coeffBus1;
    logic               coeffReady1;
    logic               coeffError1;
    logic               busy1;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] stub_vals [LEN];
    int stub_flag_at = LEN - 1;
    int s_cnt;
    int s_cnt1;

    int nom_tbl [LEN] = '{34124, -1200, 5000, -25000, 77, -7711, 131071, 81122,
                          -131072, 1, -1, 2048, -4096, 9999, -9999, 12345,
                          -54321, 65535, -65536, 10000};

    always #5 clock = ~clock;

    fir_coeff_loader #(.LENGTH(LEN), .DATA_WIDTH(DW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .loadStart      (loadStart),
        .coeffIn        (coeffIn),
        .coeffSetFlagIn (coeffSetFlagIn),
        .coeffRequest   (coeffRequest),
        .coeffBus       (coeffBus),
        .coeffReady     (coeffReady),
        .coeffError     (coeffError),
        .busy           (busy)
    );

    fir_coeff_loader #(.LENGTH(1), .DATA_WIDTH(DW)) dut1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .loadStart      (loadStart1),
        .coeffIn        (coeffIn1),
        .coeffSetFlagIn (coeffSetFlagIn1),
        .coeffRequest   (coeffRequest1),
        .coeffBus       (coeffBus1),
        .coeffReady     (coeffReady1),
        .coeffError     (coeffError1),
        .busy           (busy1)
    );

    // Setup-block stub: registers word k one edge after it samples enable, flags the chosen word, then emits one stray word.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt          <= 0;
            coeffIn        <= '0;
            coeffSetFlagIn <= 1'b0;
        end else if (coeffRequest) begin
            coeffIn        <= (s_cnt < LEN) ? stub_vals[s_cnt] : 18'h2AAAA;
            coeffSetFlagIn <= (s_cnt == stub_flag_at);
            s_cnt          <= s_cnt + 1;
        end else begin
            s_cnt          <= 0;
            coeffSetFlagIn <= 1'b0;
        end
    end

    // Single-word stub for the LENGTH=1 instance.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt1          <= 0;
            coeffIn1        <= '0;
            coeffSetFlagIn1 <= 1'b0;
        end else if (coeffRequest1) begin
            coeffIn1        <= (s_cnt1 == 0) ? 18'(34124) : 18'h2AAAA;
            coeffSetFlagIn1 <= (s_cnt1 == 0);
            s_cnt1          <= s_cnt1 + 1;
        end else begin
            s_cnt1          <= 0;
            coeffSetFlagIn1 <= 1'b0;
        end
    end

    function automatic logic [DW-1:0] tap(input int k);
        return coeffBus[k*DW +: DW];
    endfunction

    task automatic set_stub(input int base, input int flag_at, input bit use_nom);
        for (int k = 0; k < LEN; k++) begin
            stub_vals[k] = use_nom ? DW'(nom_tbl[k]) : DW'(base + k);
        end
        stub_flag_at = flag_at;
    endtask

    // Pulse loadStart, then sample once per cycle (sample c follows edge E_c).
    // p1/p2 re-pulse loadStart so that it is seen at edge E_(p+1).
    task automatic watch(input int limit, input int p1, input int p2,
                         output int rdy_e, output int busy_e, output int req_n,
                         output logic rdy0);
        rdy_e = -1; busy_e = -1; req_n = 0; rdy0 = 1'bx;
        loadStart = 1'b1;
        @(negedge clock);
        for (int c = 0; c < limit; c++) begin
            if (c == 0) rdy0 = coeffReady;
            if (coeffRequest) req_n++;
            if (rdy_e < 0 && coeffReady) rdy_e = c;
            if (busy_e < 0 && !busy) busy_e = c;
            loadStart = (c == p1) || (c == p2);
            @(negedge clock);
        end
        loadStart = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        vectors++; if (coeffRequest !== 1'b0) begin miscompares++; $display("FAIL reset_request: got %b want 0", coeffRequest); end
        vectors++; if (coeffReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", coeffReady); end
        vectors++; if (coeffError !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", coeffError); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (coeffBus !== '0) begin miscompares++; $display("FAIL reset_bus: got %h want 0", coeffBus); end
        vectors++; if (coeffBus1 !== '0 || coeffRequest1 !== 1'b0) begin miscompares++; $display("FAIL reset_len1: bus %h req %b want 0 0", coeffBus1, coeffRequest1); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_nominal();
        int rdy_e, busy_e, req_n;
        logic rdy0;
        set_stub(0, LEN - 1, 1'b1);
        watch(30, -1, -1, rdy_e, busy_e, req_n, rdy0);
        vectors++; if (rdy_e !== 21) begin miscompares++; $display("FAIL nom_ready_edge: got %0d want 21", rdy_e); end
        vectors++; if (req_n !== 21) begin miscompares++; $display("FAIL nom_request_cycles: got %0d want 21", req_n); end
        vectors++; if (busy_e !== 21) begin miscompares++; $display("FAIL nom_busy_edge: got %0d want 21", busy_e); end
        vectors++; if (coeffError !== 1'b0) begin miscompares++; $display("FAIL nom_error: got %b want 0", coeffError); end
        vectors++; if (coeffReady !== 1'b1) begin miscompares++; $display("FAIL nom_ready: got %b want 1", coeffReady); end
        vectors++; if (tap(0) !== DW'(34124)) begin miscompares++; $display("FAIL nom_tap0: got %0d want 34124", $signed(tap(0))); end
        vectors++; if (tap(5) !== DW'(-7711)) begin miscompares++; $display("FAIL nom_tap5: got %0d want -7711", $signed(tap(5))); end
        vectors++; if (tap(7) !== DW'(81122)) begin miscompares++; $display("FAIL nom_tap7: got %0d want 81122", $signed(tap(7))); end
        vectors++; if (tap(8) !== DW'(-131072)) begin miscompares++; $display("FAIL nom_tap8: got %0d want -131072", $signed(tap(8))); end
        vectors++; if (tap(19) !== DW'(10000)) begin miscompares++; $display("FAIL nom_tap19: got %0d want 10000", $signed(tap(19))); end
    endtask

    task automatic test_reload();
        int rdy_e, busy_e, req_n;
        logic rdy0;
        set_stub(1, LEN - 1, 1'b0);
        watch(30, 0, 10, rdy_e, busy_e, req_n, rdy0);
        vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL reload_ready_drop: got %b want 0", rdy0); end
        vectors++; if (rdy_e !== 21) begin miscompares++; $display("FAIL reload_ready_edge: got %0d want 21", rdy_e); end
        vectors++; if (req_n !== 21) begin miscompares++; $display("FAIL reload_request_cycles: got %0d want 21", req_n); end
        vectors++; if (tap(19) !== DW'(20)) begin miscompares++; $display("FAIL reload_tap19: got %0d want 20", $signed(tap(19))); end
        vectors++; if (tap(0) !== DW'(1)) begin miscompares++; $display("FAIL reload_tap0: got %0d want 1", $signed(tap(0))); end
        vectors++; if (coeffError !== 1'b0) begin miscompares++; $display("FAIL reload_error: got %b want 0", coeffError); end
    endtask

    task automatic test_early_flag();
        int rdy_e, busy_e, req_n;
        logic rdy0;
        set_stub(100, 9, 1'b0);
        watch(30, -1, -1, rdy_e, busy_e, req_n, rdy0);
        vectors++; if (busy_e !== 11) begin miscompares++; $display("FAIL early_busy_edge: got %0d want 11", busy_e); end
        vectors++; if (req_n !== 11) begin miscompares++; $display("FAIL early_request_cycles: got %0d want 11", req_n); end
        vectors++; if (coeffError !== 1'b1) begin miscompares++; $display("FAIL early_error: got %b want 1", coeffError); end
        vectors++; if (coeffReady !== 1'b0 || rdy_e !== -1) begin miscompares++; $display("FAIL early_ready: got %b/%0d want 0/-1", coeffReady, rdy_e); end
        vectors++; if (tap(9) !== DW'(109)) begin miscompares++; $display("FAIL early_tap9: got %0d want 109", $signed(tap(9))); end
        vectors++; if (tap(0) !== DW'(100)) begin miscompares++; $display("FAIL early_tap0: got %0d want 100", $signed(tap(0))); end
        vectors++; if (tap(10) !== DW'(11)) begin miscompares++; $display("FAIL early_tap10: got %0d want 11", $signed(tap(10))); end
        vectors++; if (tap(19) !== DW'(20)) begin miscompares++; $display("FAIL early_tap19: got %0d want 20", $signed(tap(19))); end
    endtask

    task automatic test_missing_flag();
        int rdy_e, busy_e, req_n;
        logic rdy0;
        set_stub(200, -1, 1'b0);
        watch(30, -1, -1, rdy_e, busy_e, req_n, rdy0);
        vectors++; if (busy_e !== 21) begin miscompares++; $display("FAIL missing_busy_edge: got %0d want 21", busy_e); end
        vectors++; if (coeffError !== 1'b1) begin miscompares++; $display("FAIL missing_error: got %b want 1", coeffError); end
        vectors++; if (coeffRequest !== 1'b0) begin miscompares++; $display("FAIL missing_request: got %b want 0", coeffRequest); end
        vectors++; if (coeffReady !== 1'b0 || rdy_e !== -1) begin miscompares++; $display("FAIL missing_ready: got %b/%0d want 0/-1", coeffReady, rdy_e); end
        vectors++; if (tap(19) !== DW'(219)) begin miscompares++; $display("FAIL missing_tap19: got %0d want 219", $signed(tap(19))); end
        vectors++; if (tap(0) !== DW'(200)) begin miscompares++; $display("FAIL missing_tap0_nowrap: got %0d want 200", $signed(tap(0))); end
    endtask

    task automatic test_reset_mid_load();
        int rdy_e, busy_e, req_n;
        logic rdy0;
        set_stub(0, LEN - 1, 1'b1);
        loadStart = 1'b1;
        @(negedge clock);
        loadStart = 1'b0;
        repeat (9) @(negedge clock);
        vectors++; if (busy !== 1'b1 || tap(7) !== DW'(81122)) begin miscompares++; $display("FAIL midload_progress: busy %b tap7 %0d want 1 81122", busy, $signed(tap(7))); end
        reset_n = 1'b0;
        #1;
        vectors++; if (coeffRequest !== 1'b0) begin miscompares++; $display("FAIL midload_request: got %b want 0", coeffRequest); end
        vectors++; if (coeffBus !== '0) begin miscompares++; $display("FAIL midload_bus: got %h want 0", coeffBus); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midload_busy: got %b want 0", busy); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        watch(30, -1, -1, rdy_e, busy_e, req_n, rdy0);
        vectors++; if (rdy_e !== 21) begin miscompares++; $display("FAIL after_reset_ready_edge: got %0d want 21", rdy_e); end
        vectors++; if (tap(19) !== DW'(10000)) begin miscompares++; $display("FAIL after_reset_tap19: got %0d want 10000", $signed(tap(19))); end
        vectors++; if (coeffError !== 1'b0) begin miscompares++; $display("FAIL after_reset_error: got %b want 0", coeffError); end
    endtask

    task automatic test_length1();
        int rdy_e = -1;
        int req_n = 0;
        loadStart1 = 1'b1;
        @(negedge clock);
        loadStart1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (coeffRequest1) req_n++;
            if (rdy_e < 0 && coeffReady1) rdy_e = c;
            @(negedge clock);
        end
        vectors++; if (rdy_e !== 2) begin miscompares++; $display("FAIL len1_ready_edge: got %0d want 2", rdy_e); end
        vectors++; if (req_n !== 2) begin miscompares++; $display("FAIL len1_request_cycles: got %0d want 2", req_n); end
        vectors++; if (coeffBus1 !== DW'(34124)) begin miscompares++; $display("FAIL len1_tap0: got %0d want 34124", $signed(coeffBus1)); end
        vectors++; if (coeffError1 !== 1'b0) begin miscompares++; $display("FAIL len1_error: got %b want 0", coeffError1); end
    endtask

    initial begin
        for (int k = 0; k < LEN; k++) stub_vals[k] = '0;
        test_reset();
        test_nominal();
        test_reload();
        test_early_flag();
        test_missing_flag();
        test_reset_mid_load();
        test_length1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
